// File: rtl/msdf_pkg.sv
// Shared definitions for the MSDF online multiplier controller: FSM encoding
// and a constant-foldable ceiling-log2 used to size the step counter.
package msdf_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 <<< i) < v) begin
        r = i + 1;
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/msdf_step_decode.sv
// Per-step strobe decode for the MSDF multiplier datapath: maps the step
// enable and step index k onto the register load strobes and output digit tag.
module msdf_step_decode #(
  parameter int N     = 9,
  parameter int DELTA = 3,
  parameter int CW    = 4
) (
  input  logic          en,
  input  logic [CW-1:0] k,
  input  logic [CW-1:0] p,
  output logic          load_lx,
  output logic          load_ly,
  output logic          load_ca_x,
  output logic          load_ca_y,
  output logic          load_wc,
  output logic          load_ws,
  output logic          load_pj,
  output logic          zj_valid,
  output logic [CW-1:0] z_idx
);

  localparam logic [CW-1:0] N_C     = CW'(N);
  localparam logic [CW-1:0] DELTA_C = CW'(DELTA);
  localparam logic [CW-1:0] ONE_C   = CW'(1);

  logic in_win_s;
  logic cax_win_s;
  logic out_win_s;
  logic pj_win_s;

  // Step windows; output digits are additionally bounded by the product length
  always_comb begin
    in_win_s  = (k < N_C);
    cax_win_s = (k >= ONE_C) && (k <= N_C);
    out_win_s = (k >= DELTA_C) && ((k - DELTA_C) < p);
    pj_win_s  = (k >= (DELTA_C + ONE_C)) && out_win_s;
  end

  // Strobes qualified by the step enable; z_idx idles at zero
  always_comb begin
    load_lx   = en && in_win_s;
    load_ly   = en && in_win_s;
    load_ca_y = en && in_win_s;
    load_ca_x = en && cax_win_s;
    load_wc   = en;
    load_ws   = en;
    load_pj   = en && pj_win_s;
    zj_valid  = en && out_win_s;
    if (en && out_win_s) begin
      z_idx = k - DELTA_C;
    end else begin
      z_idx = {CW{1'b0}};
    end
  end

endmodule

// File: rtl/msdf_mul_ctrl.sv
// Control FSM for a radix-2 most-significant-digit-first online multiplier:
// sequences input acceptance, recurrence steps, and output digit emission.
module msdf_mul_ctrl
  import msdf_pkg::*;
#(
  parameter int N     = 9,
  parameter int DELTA = 3,
  localparam int CW   = clog2(N + DELTA + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [CW-1:0] p_len,
  input  logic          abort,
  input  logic          in_valid,
  output logic          in_ready,
  output logic          load_lx,
  output logic          load_ly,
  output logic          load_ca_x,
  output logic          load_ca_y,
  output logic          load_wc,
  output logic          load_ws,
  output logic          load_pj,
  output logic          zj_valid,
  output logic [CW-1:0] z_idx,
  output logic          clear_regs,
  output logic          busy,
  output logic          done
);

  localparam logic [CW-1:0] N_C     = CW'(N);
  localparam logic [CW-1:0] DELTA_C = CW'(DELTA);
  localparam logic [CW-1:0] ONE_C   = CW'(1);

  state_e        state_r;
  state_e        state_nx_s;
  logic [CW-1:0] k_r;
  logic [CW-1:0] p_r;
  logic [CW-1:0] p_sel_s;
  logic [CW-1:0] k_last_s;
  logic          run_s;
  logic          in_win_s;
  logic          en_s;
  logic          last_s;

  // Out-of-range product lengths fall back to the full N digits
  always_comb begin
    if ((p_len == {CW{1'b0}}) || (p_len > N_C)) begin
      p_sel_s = N_C;
    end else begin
      p_sel_s = p_len;
    end
  end

  // Step enable: inputs gate steps while operands arrive, drain steps are free
  always_comb begin
    run_s    = (state_r == ST_RUN);
    in_win_s = (k_r < N_C);
    k_last_s = DELTA_C + p_r - ONE_C;
    last_s   = (k_r == k_last_s);
    if (run_s && !abort) begin
      if (in_win_s) begin
        en_s = in_valid;
      end else begin
        en_s = 1'b1;
      end
    end else begin
      en_s = 1'b0;
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Step counter and latched product length
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      k_r <= {CW{1'b0}};
      p_r <= N_C;
    end else begin
      if ((state_r == ST_IDLE) && start) begin
        k_r <= {CW{1'b0}};
        p_r <= p_sel_s;
      end else if (en_s) begin
        k_r <= k_r + ONE_C;
      end else if (state_r != ST_RUN) begin
        k_r <= {CW{1'b0}};
      end else begin
        k_r <= k_r;
      end
    end
  end

  // Next-state logic; abort wins over any step in progress
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_nx_s = ST_RUN;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (abort) begin
          state_nx_s = ST_IDLE;
        end else if (en_s && last_s) begin
          state_nx_s = ST_DONE;
        end else begin
          state_nx_s = ST_RUN;
        end
      end
      ST_DONE: state_nx_s = ST_IDLE;
      default: state_nx_s = ST_IDLE;
    endcase
  end

  // FSM outputs; clear_regs is held low while reset is asserted
  always_comb begin
    busy       = run_s;
    in_ready   = run_s && in_win_s;
    done       = (state_r == ST_DONE) && !abort;
    clear_regs = rst && (state_r == ST_IDLE) && start;
  end

  msdf_step_decode #(
    .N     (N),
    .DELTA (DELTA),
    .CW    (CW)
  ) u_decode (
    .en        (en_s),
    .k         (k_r),
    .p         (p_r),
    .load_lx   (load_lx),
    .load_ly   (load_ly),
    .load_ca_x (load_ca_x),
    .load_ca_y (load_ca_y),
    .load_wc   (load_wc),
    .load_ws   (load_ws),
    .load_pj   (load_pj),
    .zj_valid  (zj_valid),
    .z_idx     (z_idx)
  );

endmodule

// File: tb/tb_msdf_mul_ctrl.sv
// Self-checking bench for msdf_mul_ctrl (N=9, DELTA=3) against a step-level
// reference model of the online multiplier schedule.
module tb_msdf_mul_ctrl;

  localparam int N     = 9;
  localparam int DELTA = 3;
  localparam int CW    = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [CW-1:0] p_len;
  logic          abort;
  logic          in_valid;
  logic          in_ready;
  logic          load_lx, load_ly, load_ca_x, load_ca_y;
  logic          load_wc, load_ws, load_pj, zj_valid;
  logic [CW-1:0] z_idx;
  logic          clear_regs, busy, done;
  logic [15:0]   obs_v;

  int n_pass  = 0;
  int n_total = 0;
  int busy_cnt, done_cnt, z_cnt;
  bit z_order_ok, was_aborted;

  always #5 clk = ~clk;

  assign obs_v = {busy, in_ready, load_lx, load_ly, load_ca_x, load_ca_y, load_wc, load_ws,
                  load_pj, zj_valid, z_idx, done, clear_regs};

  msdf_mul_ctrl #(.N(N), .DELTA(DELTA)) dut (
    .clk(clk), .rst(rst), .start(start), .p_len(p_len), .abort(abort),
    .in_valid(in_valid), .in_ready(in_ready),
    .load_lx(load_lx), .load_ly(load_ly), .load_ca_x(load_ca_x), .load_ca_y(load_ca_y),
    .load_wc(load_wc), .load_ws(load_ws), .load_pj(load_pj),
    .zj_valid(zj_valid), .z_idx(z_idx), .clear_regs(clear_regs),
    .busy(busy), .done(done)
  );

  // One operation: model tracks completed step count s and checks every cycle.
  // mode 0: in_valid always 1; 1: two stall cycles at s=5; 2: random in_valid
  task automatic run_op(input int plen, input int mode, input bit hold_start, input int abort_at);
    int p, s, stalls_left, phase;
    bit iv, ab, e_run, e_en, e_lx, e_cax, e_z, e_pj;
    logic [3:0]  e_zidx;
    logic [15:0] exp_v;
    p = (plen >= 1 && plen <= N) ? plen : N;
    busy_cnt = 0; done_cnt = 0; z_cnt = 0; z_order_ok = 1'b1; was_aborted = 1'b0;
    @(negedge clk);
    start = 1'b1; p_len = 4'(plen); abort = 1'b0; in_valid = 1'($urandom_range(0, 1));
    #1;
    exp_v = 16'h0001;
    n_total++;
    if (obs_v !== exp_v) $display("FAIL start_cycle: got %h expected %h", obs_v, exp_v);
    else n_pass++;
    s = 0; stalls_left = 2; phase = 0;
    for (int cyc = 0; cyc < 200 && phase != 2; cyc++) begin
      @(negedge clk);
      start = hold_start;
      p_len = 4'($urandom);
      case (mode)
        0: iv = 1'b1;
        1: begin
          iv = !(phase == 0 && s == 5 && stalls_left > 0);
          if (!iv) stalls_left--;
        end
        default: iv = ($urandom_range(0, 3) != 0);
      endcase
      ab = (phase == 0) && (s == abort_at);
      in_valid = iv; abort = ab;
      e_run  = (phase == 0);
      e_en   = e_run && !ab && ((s < N) ? iv : 1'b1);
      e_lx   = e_en && (s < N);
      e_cax  = e_en && (s >= 1) && (s <= N);
      e_z    = e_en && (s >= DELTA);
      e_pj   = e_en && (s >= DELTA + 1);
      e_zidx = e_z ? 4'(s - DELTA) : 4'd0;
      exp_v  = {e_run, e_run && (s < N), e_lx, e_lx, e_cax, e_lx, e_en, e_en,
                e_pj, e_z, e_zidx, phase == 1, 1'b0};
      #1;
      n_total++;
      if (obs_v !== exp_v)
        $display("FAIL cycle plen=%0d step=%0d: got %h expected %h", plen, s, obs_v, exp_v);
      else n_pass++;
      if (busy) busy_cnt++;
      if (done) done_cnt++;
      if (zj_valid) begin
        if (z_idx !== 4'(z_cnt)) z_order_ok = 1'b0;
        z_cnt++;
      end
      if (phase == 1) phase = 2;
      else if (ab) begin phase = 2; was_aborted = 1'b1; end
      else if (e_en) begin
        s++;
        if (s == DELTA + p) phase = 1;
      end
    end
    n_total++;
    if (phase != 2) $display("FAIL timeout: operation did not complete, phase %0d expected 2", phase);
    else n_pass++;
    @(negedge clk);
    start = 1'b0; abort = 1'b0; in_valid = 1'b0;
    #1;
    n_total++;
    if (obs_v !== 16'h0000) $display("FAIL idle_after: got %h expected 0000", obs_v);
    else n_pass++;
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 1'b1; p_len = 4'd9; abort = 1'b0; in_valid = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    n_total++;
    if (obs_v !== 16'h0000) $display("FAIL reset_outputs: got %h expected 0000", obs_v);
    else n_pass++;
    start = 1'b0; in_valid = 1'b0; rst = 1'b1;
    @(negedge clk); #1;
    n_total++;
    if (obs_v !== 16'h0000) $display("FAIL reset_idle: got %h expected 0000", obs_v);
    else n_pass++;
  endtask

  task automatic test_full();
    run_op(9, 0, 1'b0, -1);
    n_total++;
    if (busy_cnt !== 12) $display("FAIL full_busy: got %0d expected 12", busy_cnt); else n_pass++;
    n_total++;
    if (z_cnt !== 9 || !z_order_ok) $display("FAIL full_digits: got %0d ok=%0d expected 9 ok=1", z_cnt, z_order_ok);
    else n_pass++;
    n_total++;
    if (done_cnt !== 1) $display("FAIL full_done: got %0d expected 1", done_cnt); else n_pass++;
  endtask

  task automatic test_truncated();
    run_op(4, 0, 1'b0, -1);
    n_total++;
    if (busy_cnt !== 7) $display("FAIL trunc_busy: got %0d expected 7", busy_cnt); else n_pass++;
    n_total++;
    if (z_cnt !== 4) $display("FAIL trunc_digits: got %0d expected 4", z_cnt); else n_pass++;
  endtask

  task automatic test_stall();
    run_op(9, 1, 1'b0, -1);
    n_total++;
    if (busy_cnt !== 14) $display("FAIL stall_busy: got %0d expected 14", busy_cnt); else n_pass++;
    n_total++;
    if (z_cnt !== 9) $display("FAIL stall_digits: got %0d expected 9", z_cnt); else n_pass++;
  endtask

  task automatic test_abort();
    run_op(9, 0, 1'b0, 7);
    n_total++;
    if (done_cnt !== 0 || busy_cnt !== 8)
      $display("FAIL abort_run: got done=%0d busy=%0d expected done=0 busy=8", done_cnt, busy_cnt);
    else n_pass++;
    run_op(9, 0, 1'b0, -1);
    n_total++;
    if (busy_cnt !== 12) $display("FAIL abort_rerun: got %0d expected 12", busy_cnt); else n_pass++;
  endtask

  task automatic test_rst_midop();
    @(negedge clk);
    start = 1'b1; p_len = 4'd9; in_valid = 1'b1; abort = 1'b0;
    repeat (7) @(negedge clk);
    #1;
    n_total++;
    if (busy !== 1'b1) $display("FAIL rst_pre_busy: got %0b expected 1", busy); else n_pass++;
    rst = 1'b0;
    #1;
    n_total++;
    if (obs_v !== 16'h0000) $display("FAIL rst_async: got %h expected 0000", obs_v); else n_pass++;
    @(negedge clk); #1;
    n_total++;
    if (obs_v !== 16'h0000) $display("FAIL rst_hold: got %h expected 0000", obs_v); else n_pass++;
    start = 1'b0; rst = 1'b1;
    run_op(9, 0, 1'b1, -1);
    n_total++;
    if (busy_cnt !== 12 || done_cnt !== 1)
      $display("FAIL rst_rerun: got busy=%0d done=%0d expected busy=12 done=1", busy_cnt, done_cnt);
    else n_pass++;
  endtask

  task automatic test_plen_edge();
    run_op(0, 0, 1'b0, -1);
    n_total++;
    if (z_cnt !== 9) $display("FAIL plen0_digits: got %0d expected 9", z_cnt); else n_pass++;
    run_op(12, 0, 1'b0, -1);
    n_total++;
    if (z_cnt !== 9) $display("FAIL plen12_digits: got %0d expected 9", z_cnt); else n_pass++;
    run_op(1, 0, 1'b0, -1);
    n_total++;
    if (z_cnt !== 1 || busy_cnt !== 4)
      $display("FAIL plen1: got digits=%0d busy=%0d expected 1 and 4", z_cnt, busy_cnt);
    else n_pass++;
  endtask

  task automatic test_random();
    int plen, p, ab_at;
    for (int i = 0; i < 25; i++) begin
      plen  = $urandom_range(0, 15);
      p     = (plen >= 1 && plen <= N) ? plen : N;
      ab_at = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 14)) : -1;
      run_op(plen, 2, 1'($urandom_range(0, 1)), ab_at);
      n_total++;
      if (!was_aborted && (z_cnt !== p || done_cnt !== 1 || !z_order_ok))
        $display("FAIL random_op%0d: got digits=%0d done=%0d expected digits=%0d done=1", i, z_cnt, done_cnt, p);
      else if (was_aborted && done_cnt !== 0)
        $display("FAIL random_abort%0d: got done=%0d expected 0", i, done_cnt);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_full();
    test_truncated();
    test_stall();
    test_abort();
    test_rst_midop();
    test_plen_edge();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
